// File: rtl/flat_buffer_serializer_if.sv
// Stream-side bundle for flat_buffer_serializer.
// Each transfer carries one signed sample with its channel and delay index.
interface flat_buffer_serializer_if #(
  parameter int numChannels = 16,
  parameter int bitwidth    = 8,
  parameter int depth       = 5
);
  localparam int CW = (numChannels > 1) ? $clog2(numChannels) : 1;
  localparam int DW = (depth > 0) ? $clog2(depth + 1) : 1;

  logic signed [bitwidth-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [CW-1:0]              out_ch;
  logic [DW-1:0]              out_dly;
  logic                       out_last;

  modport master (output out_data, out_valid, out_ch, out_dly, out_last, input out_ready);
  modport slave  (input out_data, out_valid, out_ch, out_dly, out_last, output out_ready);
endinterface

// File: rtl/flat_buffer_serializer.sv
// Snapshots buffer[ch][dly] on capture and streams it oldest-delay first, channels ascending.
// Optional saturating reject counter: define FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN.
module flat_buffer_serializer #(
  parameter int numChannels = 16,
  parameter int bitwidth    = 8,
  parameter int depth       = 5
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic signed [bitwidth-1:0]  buffer [numChannels-1:0][depth:0],
  input  logic                        capture,
  flat_buffer_serializer_if.master    stream,
  output logic                        busy,
  output logic                        overrun
`ifdef FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN
  ,
  input  logic                        overrun_clr,
  output logic [7:0]                  overrun_cnt
`endif
);
  localparam int CW = (numChannels > 1) ? $clog2(numChannels) : 1;
  localparam int DW = (depth > 0) ? $clog2(depth + 1) : 1;
  localparam logic [CW-1:0] CH_MAX  = CW'(numChannels - 1);
  localparam logic [DW-1:0] DLY_MAX = DW'(depth);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                     state_reg, state_next;
  logic [CW-1:0]              ch_reg, ch_next;
  logic [DW-1:0]              dly_reg, dly_next;
  logic                       overrun_reg, overrun_next;
  logic                       take;
  logic                       xfer;
  logic                       last_word;
  logic signed [bitwidth-1:0] snap_reg [numChannels-1:0][depth:0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg   <= IDLE;
      ch_reg      <= '0;
      dly_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ch_reg      <= ch_next;
      dly_reg     <= dly_next;
      overrun_reg <= overrun_next;
    end
  end

  // The whole window is latched in one edge; the live buffer is ignored until the next take.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int c = 0; c < numChannels; c++)
        for (int d = 0; d <= depth; d++)
          snap_reg[c][d] <= '0;
    end else if (take) begin
      for (int c = 0; c < numChannels; c++)
        for (int d = 0; d <= depth; d++)
          snap_reg[c][d] <= buffer[c][d];
    end
  end

  always_comb begin
    state_next   = state_reg;
    ch_next      = ch_reg;
    dly_next     = dly_reg;
    take         = 1'b0;
    overrun_next = 1'b0;
    xfer         = (state_reg == STREAM) && stream.out_ready;
    last_word    = (state_reg == STREAM) && (dly_reg == '0) && (ch_reg == CH_MAX);
    case (state_reg)
      IDLE: begin
        if (capture) begin
          take       = 1'b1;
          state_next = STREAM;
          ch_next    = '0;
          dly_next   = DLY_MAX;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (last_word) begin
            // A capture on the closing transfer chains straight into the next frame.
            if (capture) begin
              take     = 1'b1;
              ch_next  = '0;
              dly_next = DLY_MAX;
            end else begin
              state_next = IDLE;
            end
          end else if (ch_reg == CH_MAX) begin
            ch_next  = '0;
            dly_next = dly_reg - DW'(1);
          end else begin
            ch_next = ch_reg + CW'(1);
          end
        end
        overrun_next = capture && !take;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stream.out_valid = (state_reg == STREAM);
    stream.out_last  = last_word;
    stream.out_ch    = (state_reg == STREAM) ? ch_reg : '0;
    stream.out_dly   = (state_reg == STREAM) ? dly_reg : '0;
    stream.out_data  = (state_reg == STREAM) ? snap_reg[ch_reg][dly_reg] : '0;
    busy             = (state_reg == STREAM);
    overrun          = overrun_reg;
  end

`ifdef FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_reg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      overrun_cnt_reg <= '0;
    else if (overrun_clr)
      overrun_cnt_reg <= '0;
    else if (overrun_next && (overrun_cnt_reg != 8'hFF))
      overrun_cnt_reg <= overrun_cnt_reg + 8'd1;
  end

  assign overrun_cnt = overrun_cnt_reg;
`endif
endmodule

// File: tb/tb_flat_buffer_serializer.sv
// Randomised self-checking bench for flat_buffer_serializer (4 channels, 8-bit, depth 2).
// Expected words come from a frame model built directly from the captured buffer contents.
module tb_flat_buffer_serializer;
  localparam int NC    = 4;
  localparam int BW    = 8;
  localparam int D     = 2;
  localparam int WORDS = NC * (D + 1);

  logic                 clk = 1'b0;
  logic                 rstb = 1'b0;
  logic                 capture = 1'b0;
  logic signed [BW-1:0] buffer [NC-1:0][D:0];
  logic                 busy;
  logic                 overrun;
`ifdef FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN
  logic                 overrun_clr = 1'b0;
  logic [7:0]           overrun_cnt;
`endif

  flat_buffer_serializer_if #(.numChannels(NC), .bitwidth(BW), .depth(D)) sif ();

  flat_buffer_serializer #(.numChannels(NC), .bitwidth(BW), .depth(D)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .buffer      (buffer),
    .capture     (capture),
    .stream      (sif.master),
    .busy        (busy),
    .overrun     (overrun)
`ifdef FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN
    ,
    .overrun_clr (overrun_clr),
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [BW-1:0] data;
    logic [1:0]           ch;
    logic [1:0]           dly;
    logic                 last;
  } word_t;

  word_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  // Frame model: oldest delay first, channels ascending inside each delay.
  task automatic push_frame();
    for (int d = D; d >= 0; d--)
      for (int c = 0; c < NC; c++)
        exp_q.push_back('{data: buffer[c][d], ch: 2'(c), dly: 2'(d),
                          last: (d == 0) && (c == NC - 1)});
  endtask

  task automatic set_pattern();
    for (int c = 0; c < NC; c++)
      for (int d = 0; d <= D; d++)
        buffer[c][d] = BW'(c * 16 + d - 64);
  endtask

  task automatic set_const(input int v);
    for (int c = 0; c < NC; c++)
      for (int d = 0; d <= D; d++)
        buffer[c][d] = BW'(v);
  endtask

  task automatic set_random();
    for (int c = 0; c < NC; c++)
      for (int d = 0; d <= D; d++)
        buffer[c][d] = BW'($urandom);
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  // cap_word: word index during which a (rejected) capture is pulsed, -1 for none.
  // cap_last: capture on the closing transfer with the buffer forced to -128.
  task automatic run_frame(input string name, input int ready_mode, input bit scramble,
                           input int cap_word, input bit cap_last);
    int    budget, xfers, rejects, seen;
    bit    rdy, stall_prev, last_done, cap_done;
    word_t obs, prev, e;
    budget = 0; xfers = 0; rejects = 0; seen = 0;
    stall_prev = 1'b0; last_done = 1'b0; cap_done = 1'b0;
    prev = '0;
    @(negedge clk);
    capture = 1'b1;
    push_frame();
    while (exp_q.size() > 0 && budget < 400) begin
      @(negedge clk);
      budget++;
      capture = 1'b0;
      if (scramble) set_random();
      if (overrun) seen++;
      obs = '{data: sif.out_data, ch: sif.out_ch, dly: sif.out_dly, last: sif.out_last};
      e = exp_q[0];
      checks++;
      if (sif.out_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s valid_busy word%0d: got valid=%b busy=%b want 1 1", name, xfers, sif.out_valid, busy);
      end
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s word%0d: got data=%0d ch=%0d dly=%0d last=%0d want data=%0d ch=%0d dly=%0d last=%0d",
                 name, xfers, obs.data, obs.ch, obs.dly, obs.last, e.data, e.ch, e.dly, e.last);
      end
      if (stall_prev) begin
        checks++;
        if (obs !== prev) begin
          errors++;
          $display("FAIL %s stall_hold word%0d: got %h want %h", name, xfers, obs, prev);
        end
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((budget - 1) % 4 == 0) || ((budget - 1) % 4 == 3);
        default: rdy = 1'(($urandom_range(0, 1)));
      endcase
      sif.out_ready = rdy;
      prev = obs;
      stall_prev = !rdy;
      if (!cap_done && cap_word >= 0 && xfers == cap_word) begin
        capture = 1'b1;
        cap_done = 1'b1;
        rejects++;
      end
      if (rdy) begin
        $display("xfer %s #%0d data=%0d ch=%0d dly=%0d last=%0d", name, xfers, obs.data, obs.ch, obs.dly, obs.last);
        void'(exp_q.pop_front());
        xfers++;
        if (e.last && cap_last && !last_done) begin
          last_done = 1'b1;
          set_const(-128);
          capture = 1'b1;
          push_frame();
        end
      end
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d words left want 0", name, exp_q.size());
      exp_q.delete();
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    if (overrun) seen++;
    checks++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: got valid=%b busy=%b want 0 0", name, sif.out_valid, busy);
    end
    checks++;
    if (seen != rejects) begin
      errors++;
      $display("FAIL %s overrun_pulses: got %0d want %0d", name, seen, rejects);
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    set_pattern();
    repeat (2) @(negedge clk);
    checks++;
    if ({sif.out_valid, busy, overrun, sif.out_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b busy=%b overrun=%b last=%b want 0 0 0 0",
               sif.out_valid, busy, overrun, sif.out_last);
    end
    checks++;
    if (sif.out_data !== '0 || sif.out_ch !== '0 || sif.out_dly !== '0) begin
      errors++;
      $display("FAIL reset_fields: got data=%0d ch=%0d dly=%0d want 0 0 0", sif.out_data, sif.out_ch, sif.out_dly);
    end
`ifdef FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", overrun_cnt);
    end
`endif
    rstb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    set_pattern();
    run_frame("stream", 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    set_pattern();
    run_frame("backpressure", 1, 1'b1, -1, 1'b0);
  endtask

  task automatic test_overrun();
`ifdef FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
`endif
    set_pattern();
    run_frame("overrun", 0, 1'b0, 4, 1'b0);
`ifdef FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 8'd1) begin
      errors++;
      $display("FAIL overrun_cnt_one: got %0d want 1", overrun_cnt);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    checks++;
    if (overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL overrun_cnt_clr: got %0d want 0", overrun_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    set_pattern();
    run_frame("back_to_back", 0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_mid_reset();
    int xfers, budget;
    xfers = 0; budget = 0;
    set_pattern();
    sif.out_ready = 1'b1;
    @(negedge clk);
    capture = 1'b1;
    while (xfers < 7 && budget < 100) begin
      @(negedge clk);
      budget++;
      capture = 1'b0;
      if (sif.out_valid) xfers++;
    end
    @(negedge clk);
    rstb = 1'b0;
    #1;
    checks++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || sif.out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b busy=%b data=%0d want 0 0 0", sif.out_valid, busy, sif.out_data);
    end
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    run_frame("post_reset", 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      set_random();
      run_frame("random", 2, 1'b1, -1, 1'b0);
    end
  endtask

`ifdef FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN
  task automatic test_saturation();
    int budget;
    budget = 0;
    set_pattern();
    sif.out_ready = 1'b0;
    @(negedge clk);
    capture = 1'b1;
    repeat (301) @(negedge clk);
    capture = 1'b0;
    checks++;
    if (overrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL overrun_saturate: got %0d want 255", overrun_cnt);
    end
    sif.out_ready = 1'b1;
    while (sif.out_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (sif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL saturate_drain: got valid=%b want 0", sif.out_valid);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask
`endif

  initial begin
    sif.out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flat_buffer_serializer.md
Name: flat_buffer_serializer

Overview:
- Reader for the flat per-channel history buffer: takes a snapshot of the full 2-D array `buffer[ch][dly]` on a capture strobe.
- Streams the snapshot out one signed sample per cycle over a valid/ready interface.
- Feeds debug/JTAG-side capture, or any narrow consumer that cannot take the full parallel window.
- Output order is time-ordered: oldest delay first, channels ascending within each delay.

Parameters:
- numChannels, 16, number of parallel channels in the source buffer
- bitwidth, 8, signed sample width
- depth, 5, history depth; the source array has depth+1 entries per channel (index 0 = newest)

Ports:
- clk, input, 1, sole clock; all state updates on posedge
- rstb, input, 1, reset; asynchronous, active-low
- buffer, input, signed [bitwidth-1:0] x [numChannels-1:0][depth:0], flat history array to snapshot
- capture, input, 1, snapshot request strobe
- out_data, output, signed [bitwidth-1:0], current sample
- out_valid, output, 1, out_data is valid
- out_ready, input, 1, consumer accepts the sample
- out_ch, output, $clog2(numChannels) (min 1), channel index of out_data
- out_dly, output, $clog2(depth+1) (min 1), delay index of out_data
- out_last, output, 1, final word of the frame
- busy, output, 1, frame in progress
- overrun, output, 1, one-cycle pulse when a capture is rejected

Behaviour:
- Reset: state IDLE.
  - out_valid, out_last, busy and overrun are 0.
  - out_data, out_ch and out_dly are 0.
  - Snapshot registers are 0.
  - A reset assertion mid-frame aborts the frame immediately (asynchronous); there is no partial completion after release.
- Transfer rule: a transfer occurs on a posedge where out_valid && out_ready.
- State IDLE:
  - capture=1 registers all numChannels*(depth+1) samples on that edge.
  - Sets dly=depth, ch=0 and moves to STREAM.
  - out_valid and busy go high the following cycle (latency 1 from capture to first valid word).
- State STREAM:
  - out_valid=1 and busy=1 throughout.
  - out_data = snap[ch][dly]; out_ch=ch; out_dly=dly.
  - out_last=1 when dly==0 && ch==numChannels-1.
- Index advance on each transfer:
  - ch increments.
  - When ch==numChannels-1, ch wraps to 0 and dly decrements.
- Frame end: transfer with out_last=1.
  - Returns to IDLE; out_valid drops next cycle.
  - If capture=1 on that same edge: back-to-back case. Take a new snapshot, reset the indices and stay in STREAM with no idle bubble.
- Backpressure:
  - While out_ready=0, out_data, out_ch, out_dly and out_last are held stable.
  - Changes on the live buffer input do not affect the snapshot.
- Capture during STREAM (other than the frame-end edge):
  - Ignored; the snapshot is unchanged.
  - overrun pulses high for exactly one cycle per rejected capture edge.
- Frame length: exactly numChannels*(depth+1) transfers.
- depth=0: one word per channel.
- Values pass through bit-exact and sign-preserving; no arithmetic.

Optional Feature:
- Macro: FLAT_BUFFER_SERIALIZER_OVERRUN_CNT_EN
- Defined:
  - Adds output overrun_cnt [7:0]: a saturating count of rejected captures; holds at 255.
  - Adds input overrun_clr: synchronous clear to 0, with priority over an increment on the same edge.
  - overrun_cnt resets to 0.
- Undefined: neither port exists; only the overrun pulse is provided.

Test Plan (numChannels=4, bitwidth=8, depth=2, buffer[ch][d]=ch*16+d-64 unless stated):
- Capture with out_ready held 1:
  - 12 words follow, starting one cycle after capture.
  - Sequence is -62,-46,-30,-14,-63,-47,-31,-15,-64,-48,-32,-16.
  - out_dly runs 2,2,2,2,1…0; out_last is set only on word 12; busy is low after.
- Backpressure: out_ready toggles 1,0,0,1 repeating, and buffer inputs change every cycle after capture.
  - Same 12 values as above.
  - Outputs are stable during stalls.
- Capture pulsed at word 5 of a frame:
  - overrun pulses for one cycle.
  - The frame completes with the original values.
  - With the macro defined, overrun_cnt=1; after overrun_clr, overrun_cnt=0.
- Capture on the out_last transfer edge with the buffer set to all -128:
  - Next cycle out_valid stays 1 and out_data=-128 for 12 words.
  - No overrun.
- rstb pulsed low after word 7:
  - out_valid, busy and out_data are 0 immediately.
  - After release, a new capture gives a full 12-word frame starting at dly=2, ch=0.
- 300 rejected captures with the macro defined: overrun_cnt saturates at 255.
